mul_operand_sequencer: RTL
==========================

Name: mul_operand_sequencer

Overview:
- Upstream feeder for the repeated-addition multiplier (datapath + controller pair).
- Accepts operand pairs (A, B) over a valid/ready handshake and buffers them in a small FIFO.
- Replays each pair onto the multiplier's shared data_in bus in a fixed start / A / B sequence, then waits for the multiplier's done.
- Counts completed operations and flags operations that never complete.

Parameters:
- W, 16, operand width; matches the multiplier data_in width.
- DEPTH, 2, operand-pair FIFO depth (power of two, ≥ 2).
- TIMEOUT, 64, max cycles in WAIT before the operation is abandoned.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream operand pair valid.
- in_ready  output  1  FIFO can accept a pair.
- in_a  input  W  multiplicand.
- in_b  input  W  multiplier (repeat count).
- mul_start  output  1  start strobe to the multiplier controller.
- mul_data  output  W  drives the multiplier data_in bus.
- mul_done  input  1  done level from the multiplier controller.
- busy  output  1  high in any state other than IDLE.
- timeout_err  output  1  sticky; set on any timeout.
- op_count  output  8  completed-operation counter.

Behaviour:
- Reset: asynchronous on rst_n low; all registers clear immediately.
  - mul_start=0, mul_data=0, busy=0, timeout_err=0, op_count=0.
  - FIFO empty, so in_ready=1. State=IDLE. Done-edge register=0.
- Clock and reset: one clock domain. All outputs are registered except in_ready, which is the combinational negation of FIFO full.
- Push: occurs when in_valid && in_ready at a rising edge; {in_a, in_b} is written to the FIFO.
- Full FIFO: in_ready=0. No push occurs even if a pop happens in the same cycle (no pass-through).
- Pop: only in IDLE, when the FIFO is non-empty. A pushed pair is poppable at the earliest on the edge after its push.
- FSM states: IDLE, START, SEND_A, SEND_B, WAIT.
  - IDLE: mul_data=0, mul_start=0. If the FIFO is non-empty, pop into the op registers and go to START.
  - START (1 cycle): mul_start=1, mul_data=A. Go to SEND_A.
  - SEND_A (1 cycle): mul_start=0, mul_data=A. Go to SEND_B.
  - SEND_B (1 cycle): mul_data=B. Clear the wait counter. Go to WAIT.
  - WAIT: mul_data holds B; the wait counter increments each cycle.
    - On a rising edge of mul_done (mul_done=1 and previous sample 0): op_count+1 (wraps 255→0), go to IDLE.
    - Else, when the counter reaches TIMEOUT-1: set timeout_err, drop the operation, go to IDLE.
- Done detection: mul_done is sampled every cycle into the edge register but acted on only in WAIT.
  - A mul_done level held high from a previous operation does not complete the new one; a fresh 0→1 transition is required.
- Same-cycle done rising edge and timeout: completion wins; timeout_err is not set.
- Latency:
  - Pop edge → mul_start high on the next cycle.
  - A is presented for 2 cycles (START, SEND_A); B appears 2 cycles after mul_start.
  - Minimum IDLE→IDLE occupancy is 4 cycles plus multiplier time.
- Back-to-back operations: after returning to IDLE with a non-empty FIFO, the next pop occurs on the following edge. IDLE lasts ≥1 cycle between operations.
- B=0: forwarded unchanged; handling is the multiplier's responsibility.
- Reset mid-operation: the FSM aborts; buffered pairs are discarded; op_count and timeout_err clear.

Test Plan:
- Single operation: push A=17, B=5. Expect:
  - mul_start high for exactly 1 cycle, with mul_data=17 that cycle and the next.
  - mul_data=5 from the following cycle.
  - A mul_done rise gives op_count=1, busy=0 on the next cycle.
- Back-pressure: push 3 pairs (3×4, 7×2, 9×9) on consecutive cycles while the first operation waits. Expect:
  - in_ready=0 once 2 pairs are buffered; the third pair is accepted only after a pop.
  - Operations issue in FIFO order; op_count=3 at the end.
- Timeout: push 2×2 and never raise mul_done. Expect timeout_err=1 after TIMEOUT cycles in WAIT, return to IDLE, op_count=0, and the next queued pair still issued.
- Stale done: hold mul_done=1 continuously across the issue of a second operation. Expect that operation to stay in WAIT until mul_done falls and rises again.
- Reset mid-WAIT: drop rst_n during WAIT with 1 pair queued. Expect all outputs at reset values immediately and no further mul_start after release until a new push.
- Counter wrap: complete 256 operations. Expect op_count to read 255, then 0.

Source files
------------

// File: rtl/mul_operand_sequencer.sv
// Operand feeder for the repeated-addition multiplier.
// Buffers (A, B) pairs in a small FIFO, replays each one onto the multiplier's
// shared data bus as start/A/B, then waits for a fresh rising edge of done.
// Counts completed operations and raises a sticky flag for abandoned ones.
module mul_operand_sequencer #(
    parameter int W       = 16,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         mul_start,
    output logic [W-1:0] mul_data,
    input  logic         mul_done,
    output logic         busy,
    output logic         timeout_err,
    output logic [7:0]   op_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND_A,
        SEND_B,
        WAIT
    } state_t;

    state_t         state_reg;
    state_t         state_next;

    // FIFO storage and pointers; the extra pointer bit separates full from empty.
    logic [W-1:0]   mem_a [DEPTH];
    logic [W-1:0]   mem_b [DEPTH];
    logic [AW:0]    wr_ptr_reg;
    logic [AW:0]    rd_ptr_reg;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           pop;
    logic [W-1:0]   head_a;
    logic [W-1:0]   head_b;

    // Operation currently being replayed to the multiplier.
    logic [W-1:0]   op_a_reg;
    logic [W-1:0]   op_b_reg;

    logic [CW-1:0]  wait_cnt_reg;
    logic           done_prev_reg;
    logic           done_rise;
    logic           wait_expired;

    assign fifo_empty   = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                          (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    // A full FIFO refuses a push even if a pop happens on the same edge.
    assign in_ready     = !fifo_full;
    assign push         = in_valid && !fifo_full;
    assign pop          = (state_reg == IDLE) && !fifo_empty;
    assign head_a       = mem_a[rd_ptr_reg[AW-1:0]];
    assign head_b       = mem_b[rd_ptr_reg[AW-1:0]];

    // A done level left high from an earlier operation must not count; only a 0->1 edge does.
    assign done_rise    = mul_done && !done_prev_reg;
    assign wait_expired = (wait_cnt_reg == CW'(TIMEOUT - 1));

    // FIFO entries: each slot captures the incoming pair when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                    mem_a[gi] <= in_a;
                    mem_b[gi] <= in_b;
                end
            end
        end
    endgenerate

    // FIFO pointer update; a reset discards every buffered pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Next-state logic for the start/A/B/wait replay sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!fifo_empty) state_next = START;
            START:   state_next = SEND_A;
            SEND_A:  state_next = SEND_B;
            SEND_B:  state_next = WAIT;
            WAIT:    if (done_rise || wait_expired) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register and the registered bus outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            mul_start <= 1'b0;
            mul_data  <= '0;
            busy      <= 1'b0;
            op_a_reg  <= '0;
            op_b_reg  <= '0;
        end else begin
            state_reg <= state_next;
            mul_start <= (state_next == START);
            busy      <= (state_next != IDLE);
            if (pop) begin
                op_a_reg <= head_a;
                op_b_reg <= head_b;
                mul_data <= head_a;
            end else begin
                case (state_next)
                    SEND_A:       mul_data <= op_a_reg;
                    SEND_B, WAIT: mul_data <= op_b_reg;
                    default:      mul_data <= '0;
                endcase
            end
        end
    end

    // Wait counter, done edge history, completion count and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg  <= '0;
            done_prev_reg <= 1'b0;
            op_count      <= '0;
            timeout_err   <= 1'b0;
        end else begin
            done_prev_reg <= mul_done;
            if (state_reg == SEND_B) begin
                wait_cnt_reg <= '0;
            end else if (state_reg == WAIT) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
            // Completion takes priority over a timeout landing on the same cycle.
            if (state_reg == WAIT) begin
                if (done_rise) begin
                    op_count <= op_count + 8'd1;
                end else if (wait_expired) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule
